comb_decimator: RTL and testbench
=================================

# comb_decimator

Decimating comb section of the CIC decimation filter; consumes the strobed sample stream produced by the last integrator stage. Accepts every DECIM-th strobed input sample and passes it through STAGES pipelined comb (differentiator) stages, each computing y[n] = x[n] − x[n−DIFF_DELAY]. Its output is the CIC decimator output, scaled by top-bit slicing. Arithmetic is modular two's complement so integrator wrap-around cancels exactly.

## Interface
- DATA_WIDTH_INP, 18: input width; also the internal comb width W.
- DATA_WIDTH_OUT, 18: output width; must be ≤ DATA_WIDTH_INP.
- STAGES, 3: number of comb stages N, 1..8.
- DIFF_DELAY, 1: differential delay M, 1..4.
- DECIM, 8: decimation ratio R, 1..1024.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inp_samp_data  in  DATA_WIDTH_INP  signed integrator output; ignored when the strobe is low.
- inp_samp_str  in  1  input sample strobe, one cycle per sample.
- out_samp_data  out  DATA_WIDTH_OUT  signed decimated, combed sample.
- out_samp_str  out  1  output strobe, one cycle wide.

## Operation
- Decimation counter dec_cnt, range 0..DECIM−1, advances only on inp_samp_str and wraps from DECIM−1 to 0.
  - A sample is accepted when inp_samp_str=1 and dec_cnt=0, so the first strobe after reset is accepted.
  - DECIM=1 accepts every strobe.
  - Gaps between strobes do not affect the count.
- Stage 0 register captures each accepted sample and raises valid v0 for one cycle.
- Comb stage k (1..STAGES) updates only when v(k−1)=1:
  - shifts its input into a DIFF_DELAY-deep history line;
  - registers y = x − history[DIFF_DELAY−1], computed modulo 2^W with no saturation;
  - raises vk for one cycle.
- When a stage's input valid is low, its output, history and valid hold/clear as appropriate; no drift.
- Output slice: out_samp_data = final stage result[W−1 -: DATA_WIDTH_OUT]. Low bits are truncated, rounding toward −∞.
- Throughput is one sample per clock (DECIM=1, back-to-back strobes); no stalls and no backpressure.
- Reset, whether asserted at start-up or mid-operation:
  - clears dec_cnt, all history lines, stage registers, valids, out_samp_data (=0) and out_samp_str (=0);
  - discards in-flight samples;
  - strobes present while reset is high are not counted.

## Timing
- Input strobe accepted in cycle t → out_samp_str=1 in cycle t+STAGES+1 (t+STAGES+2 with rounding enabled), for exactly one cycle.
- out_samp_data is valid in the same cycle as out_samp_str and holds until the next output strobe.
- Cycle after reset deasserts: out_samp_str=0. The earliest output is STAGES+1 cycles after the first accepted strobe.
- History lines start at zero after reset. The first DIFF_DELAY outputs of each stage therefore equal the raw input minus 0.

## Configuration
- Macro COMB_DECIMATOR_ROUND_EN.
- Defined:
  - adds one output pipeline register that adds 2^(W−DATA_WIDTH_OUT−1) before slicing (round half up);
  - saturates to the maximum positive DATA_WIDTH_OUT value if the addition overflows;
  - latency becomes STAGES+2;
  - when W=DATA_WIDTH_OUT no constant is added, but the extra register is still present.
- Undefined: plain truncation, latency STAGES+1.

## Test plan
- Reset:
  - stimulus: reset high for 3 cycles while driving strobes with data 0x55;
  - required: out_samp_str=0 and out_samp_data=0 throughout and 1 cycle after; the first accepted strobe after release yields output at t+STAGES+1.
- Basic comb (STAGES=1, DIFF_DELAY=1, DECIM=1, 8-bit in and out):
  - stimulus: strobed inputs 0, 1, 3, 6;
  - required: outputs 0, 1, 2, 3, each 2 cycles after its input.
- Wrap-around (same configuration):
  - stimulus: inputs 120, then −126;
  - required: outputs 120, then 10 (modular difference).
- Decimation (DECIM=4, STAGES=1, DIFF_DELAY=1):
  - stimulus: 8 strobes carrying 0..7, with random gaps;
  - required: only 0 and 4 are accepted; outputs 0 then 4; exactly 2 output strobes.
- Full CIC (3 integrators feeding this block; STAGES=3, DECIM=8, DIFF_DELAY=1; widths 18/18):
  - stimulus: DC input 1 on every strobe;
  - required: output settles to 512 = (R·M)^N from the 4th output onward and stays constant.
- Rounding (COMB_DECIMATOR_ROUND_EN; in 8, out 4; STAGES=1, DIFF_DELAY=1; inputs 0 then 24, later 0 then 127):
  - with macro: outputs 2 and 7 (saturated);
  - without macro: outputs 1 and 7;
  - latency 3 cycles with the macro, 2 without.

Source files
------------

// File: rtl/comb_decimator.sv
// Decimating comb section of a CIC decimator: keeps every DECIM-th strobed sample and runs it through STAGES comb stages.
// Optional macro COMB_DECIMATOR_ROUND_EN adds a round-half-up, saturating output register.
module comb_decimator #(
  parameter int unsigned DATA_WIDTH_INP = 18,
  parameter int unsigned DATA_WIDTH_OUT = 18,
  parameter int unsigned STAGES         = 3,
  parameter int unsigned DIFF_DELAY     = 1,
  parameter int unsigned DECIM          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH_INP-1:0] inp_samp_data,
  input  logic                      inp_samp_str,
  output logic [DATA_WIDTH_OUT-1:0] out_samp_data,
  output logic                      out_samp_str
);

  localparam int unsigned W     = DATA_WIDTH_INP;
  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CNT_W-1:0]                        dec_cnt;
  logic                                    accept_c;
  logic [STAGES:0][W-1:0]                  chain_data;
  logic [STAGES:0]                         chain_vld;
  logic [STAGES-1:0][DIFF_DELAY-1:0][W-1:0] hist;

  assign accept_c = inp_samp_str && (dec_cnt == '0);

  // Decimation counter: advances on strobes only, so gaps never shift the phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_cnt <= '0;
    end else if (inp_samp_str) begin
      if (dec_cnt == CNT_W'(DECIM - 1)) begin
        dec_cnt <= '0;
      end else begin
        dec_cnt <= dec_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 0 capture plus comb chain; a stage only moves when its upstream valid fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_data <= '0;
      chain_vld  <= '0;
      hist       <= '0;
    end else begin
      chain_vld[0] <= accept_c;
      if (accept_c) begin
        chain_data[0] <= inp_samp_data;
      end
      for (int k = 0; k < int'(STAGES); k++) begin
        chain_vld[k+1] <= chain_vld[k];
        if (chain_vld[k]) begin
          chain_data[k+1] <= chain_data[k] - hist[k][DIFF_DELAY-1];
          hist[k][0]      <= chain_data[k];
          for (int d = 1; d < int'(DIFF_DELAY); d++) begin
            hist[k][d] <= hist[k][d-1];
          end
        end
      end
    end
  end

`ifdef COMB_DECIMATOR_ROUND_EN
  localparam int RND_SH = int'(W) - int'(DATA_WIDTH_OUT) - 1;
  localparam logic [W-1:0] RND_K = (RND_SH >= 0) ? (W'(1) << RND_SH) : '0;
  localparam logic [DATA_WIDTH_OUT-1:0] SAT_MAX =
    ~(DATA_WIDTH_OUT'(1) << (DATA_WIDTH_OUT - 1));

  logic [W-1:0] rnd_sum_c;
  logic         rnd_ovf_c;

  assign rnd_sum_c = chain_data[STAGES] + RND_K;
  // Adding a positive constant can only overflow by turning a non-negative value negative.
  assign rnd_ovf_c = ~chain_data[STAGES][W-1] & rnd_sum_c[W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_samp_data <= '0;
      out_samp_str  <= 1'b0;
    end else begin
      out_samp_str <= chain_vld[STAGES];
      if (chain_vld[STAGES]) begin
        out_samp_data <= rnd_ovf_c ? SAT_MAX : rnd_sum_c[W-1 -: DATA_WIDTH_OUT];
      end
    end
  end
`else
  // Final stage register holds between valids, so the slice is stable until the next strobe.
  assign out_samp_data = chain_data[STAGES][W-1 -: DATA_WIDTH_OUT];
  assign out_samp_str  = chain_vld[STAGES];
`endif

endmodule

// File: tb/tb_comb_decimator.sv
// Self-checking bench for comb_decimator: four parameterisations driven in sequence,
// expected outputs queued with their arrival cycle and compared when the DUT strobes.
module tb_comb_decimator;

`ifdef COMB_DECIMATOR_ROUND_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif
  localparam int LAT1 = 2 + XL;  // STAGES=1
  localparam int LAT3 = 4 + XL;  // STAGES=3

  typedef struct {
    logic [17:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]  a_in, a_out, d_in, d_out, r_in;
  logic [3:0]  r_out;
  logic [17:0] c_in, c_out;
  logic        a_si, a_so, d_si, d_so, c_si, c_so, r_si, r_so;

  comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(1), .DIFF_DELAY(1), .DECIM(1)) dut_a (
    .clk(clk), .reset(reset), .inp_samp_data(a_in), .inp_samp_str(a_si),
    .out_samp_data(a_out), .out_samp_str(a_so));
  comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(1), .DIFF_DELAY(1), .DECIM(4)) dut_d (
    .clk(clk), .reset(reset), .inp_samp_data(d_in), .inp_samp_str(d_si),
    .out_samp_data(d_out), .out_samp_str(d_so));
  comb_decimator #(.DATA_WIDTH_INP(18), .DATA_WIDTH_OUT(18), .STAGES(3), .DIFF_DELAY(1), .DECIM(8)) dut_c (
    .clk(clk), .reset(reset), .inp_samp_data(c_in), .inp_samp_str(c_si),
    .out_samp_data(c_out), .out_samp_str(c_so));
  comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(4), .STAGES(1), .DIFF_DELAY(1), .DECIM(1)) dut_r (
    .clk(clk), .reset(reset), .inp_samp_data(r_in), .inp_samp_str(r_si),
    .out_samp_data(r_out), .out_samp_str(r_so));

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   d_cnt_out = 0;
  int   c_idx = 0;
  exp_t qa[$], qd[$], qc[$], qr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compare every output strobe against the head of its scoreboard queue.
  task automatic monitor_all();
    exp_t e;
    if (a_so) begin
      chk("a_pending", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_data", 32'(a_out), 32'(e.data));
        chk("a_cycle", cyc, e.cyc);
      end
    end
    if (d_so) begin
      d_cnt_out++;
      chk("d_pending", 32'(qd.size() != 0), 32'd1);
      if (qd.size() != 0) begin
        e = qd.pop_front();
        chk("d_data", 32'(d_out), 32'(e.data));
        chk("d_cycle", cyc, e.cyc);
      end
    end
    if (c_so) begin
      chk("c_pending", 32'(qc.size() != 0), 32'd1);
      if (qc.size() != 0) begin
        e = qc.pop_front();
        chk("c_data", 32'(c_out), 32'(e.data));
        chk("c_cycle", cyc, e.cyc);
      end
      if (c_idx >= 3) chk("c_dc512", 32'(c_out), 32'd512);
      c_idx++;
    end
    if (r_so) begin
      chk("r_pending", 32'(qr.size() != 0), 32'd1);
      if (qr.size() != 0) begin
        e = qr.pop_front();
        chk("r_data", 32'(r_out), 32'(e.data));
        chk("r_cycle", cyc, e.cyc);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor_all();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk_all_idle(input string tag);
    chk({tag, "_a_str"}, 32'(a_so), 32'd0);
    chk({tag, "_a_data"}, 32'(a_out), 32'd0);
    chk({tag, "_d_str"}, 32'(d_so), 32'd0);
    chk({tag, "_c_str"}, 32'(c_so), 32'd0);
    chk({tag, "_c_data"}, 32'(c_out), 32'd0);
    chk({tag, "_r_str"}, 32'(r_so), 32'd0);
    chk({tag, "_r_data"}, 32'(r_out), 32'd0);
  endtask

  task automatic push(inout exp_t q[$], input logic [17:0] data, input int lat);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + lat;
    q.push_back(e);
  endtask

  initial begin
    logic [7:0]  a_vals[4];
    logic [7:0]  a_exp[4];
    logic [7:0]  r_vals[4];
    logic [3:0]  r_exp[4];
    logic [17:0] i1, i2, i3;
    logic [17:0] xs[4];
    logic [7:0]  prev_acc;
    int          dcnt;

    a_vals = '{8'd0, 8'd1, 8'd3, 8'd6};
    a_exp  = '{8'd0, 8'd1, 8'd2, 8'd3};
    r_vals = '{8'd0, 8'd24, 8'd0, 8'd127};
`ifdef COMB_DECIMATOR_ROUND_EN
    r_exp  = '{4'h0, 4'h2, 4'hF, 4'h7};
`else
    r_exp  = '{4'h0, 4'h1, 4'hE, 4'h7};
`endif

    // Reset held for 3 cycles with strobes carrying 0x55 on every DUT.
    reset = 1'b1;
    a_si = 1'b1; d_si = 1'b1; c_si = 1'b1; r_si = 1'b1;
    a_in = 8'h55; d_in = 8'h55; c_in = 18'h55; r_in = 8'h55;
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_all_idle("reset");
    end
    reset = 1'b0;
    a_si = 1'b0; d_si = 1'b0; c_si = 1'b0; r_si = 1'b0;
    cycle();
    chk_all_idle("post_reset");

    // Basic comb, back-to-back strobes.
    for (int i = 0; i < 4; i++) begin
      a_si = 1'b1; a_in = a_vals[i];
      push(qa, 18'(a_exp[i]), LAT1);
      cycle();
    end
    a_si = 1'b0;
    repeat (6) cycle();

    // Fresh history, then a wrapping difference.
    reset = 1'b1; cycle(); reset = 1'b0; cycle();
    a_si = 1'b1; a_in = 8'd120; push(qa, 18'd120, LAT1); cycle();
    a_in = 8'h82; push(qa, 18'd10, LAT1); cycle();
    a_si = 1'b0;
    repeat (5) cycle();

    // In-flight sample discarded by a mid-run reset; history must restart at zero.
    reset = 1'b1; cycle(); reset = 1'b0; cycle();
    a_si = 1'b1; a_in = 8'd50; cycle();
    a_si = 1'b0; reset = 1'b1; cycle();
    reset = 1'b0;
    repeat (5) cycle();
    a_si = 1'b1; a_in = 8'd7; push(qa, 18'd7, LAT1); cycle();
    a_si = 1'b0;
    repeat (5) cycle();

    // Decimation by 4 with random gaps.
    dcnt = 0; prev_acc = 8'd0;
    for (int v = 0; v < 8; v++) begin
      d_si = 1'b1; d_in = 8'(v);
      if (dcnt == 0) begin
        push(qd, 18'(8'(v) - prev_acc), LAT1);
        prev_acc = 8'(v);
      end
      dcnt = (dcnt + 1) % 4;
      cycle();
      d_si = 1'b0;
      repeat ($urandom_range(0, 3)) cycle();
    end
    repeat (6) cycle();
    chk("d_out_count", d_cnt_out, 32'd2);

    // Full CIC: three modular integrators feed the block a DC input of 1.
    i1 = '0; i2 = '0; i3 = '0; dcnt = 0;
    xs = '{18'd0, 18'd0, 18'd0, 18'd0};
    for (int n = 0; n < 64; n++) begin
      i1 = i1 + 18'd1; i2 = i2 + i1; i3 = i3 + i2;
      c_si = 1'b1; c_in = i3;
      if (dcnt == 0) begin
        xs[3] = xs[2]; xs[2] = xs[1]; xs[1] = xs[0]; xs[0] = i3;
        // Third difference in closed form: x0 - 3x1 + 3x2 - x3.
        push(qc, xs[0] - 18'(3 * xs[1]) + 18'(3 * xs[2]) - xs[3], LAT3);
      end
      dcnt = (dcnt + 1) % 8;
      cycle();
    end
    c_si = 1'b0;
    repeat (8) cycle();
    chk("c_out_count", c_idx, 32'd8);

    // Output slicing: truncation, or rounding with saturation.
    for (int i = 0; i < 4; i++) begin
      r_si = 1'b1; r_in = r_vals[i];
      push(qr, 18'(r_exp[i]), LAT1);
      cycle();
    end
    r_si = 1'b0;
    repeat (6) cycle();

    chk("a_drained", qa.size(), 32'd0);
    chk("d_drained", qd.size(), 32'd0);
    chk("c_drained", qc.size(), 32'd0);
    chk("r_drained", qr.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
